// File: rtl/tile_fb_ctrl.sv
// Tile framebuffer RAM arbiter: scan-out owns the RAM in active video, the clear
// engine then the write port share blanking. Define TILE_FB_WR_ERR_EN for sticky wr_err.
module tile_fb_ctrl #(
  parameter int HPIXELS = 640,
  parameter int VPIXELS = 480,
  parameter int TILE_PX = 20,
  parameter int HTILES  = 32,
  parameter int VTILES  = 24,
  parameter int ADDR_W  = 10,
  parameter int COLOR_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [9:0]         hc,
  input  logic [9:0]         vc,
  output logic [COLOR_W-1:0] pix_color,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [COLOR_W-1:0] wr_data,
  input  logic               clr_start,
  input  logic [COLOR_W-1:0] clr_color,
  output logic               clr_busy,
  output logic               clr_done,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic               ram_we,
  output logic [COLOR_W-1:0] ram_wdata,
  input  logic [COLOR_W-1:0] ram_rdata
`ifdef TILE_FB_WR_ERR_EN
  ,
  output logic               wr_err
`endif
);

  localparam int NTILES = HTILES * VTILES;
  localparam logic [ADDR_W-1:0] LAST_TILE = ADDR_W'(NTILES - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t             state, state_nx;
  logic [ADDR_W-1:0]  ptr, ptr_nx;
  logic [COLOR_W-1:0] col, col_nx;
  logic               active, act_d1;
  logic [9:0]         tile_x, tile_y;
  logic [ADDR_W-1:0]  scan_addr;
  logic               wr_hit, wr_oob;

  assign active    = (hc < 10'(HPIXELS)) && (vc < 10'(VPIXELS));
  assign tile_x    = hc / 10'(TILE_PX);
  assign tile_y    = vc / 10'(TILE_PX);
  assign scan_addr = ADDR_W'(tile_y * 10'(HTILES) + tile_x);

  assign wr_ready = !active && (state == IDLE) && !clr_start;
  assign wr_hit   = wr_valid && wr_ready;
  assign wr_oob   = wr_addr >= ADDR_W'(NTILES);
  assign clr_busy = (state != IDLE);
  assign clr_done = (state == DONE);

  always_comb begin
    state_nx  = state;
    ptr_nx    = ptr;
    col_nx    = col;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (active) ram_addr = scan_addr;
    unique case (state)
      IDLE: begin
        if (clr_start) begin
          state_nx = CLEAR;
          ptr_nx   = '0;
          col_nx   = clr_color;
        end else if (wr_hit && !wr_oob) begin
          ram_we    = 1'b1;
          ram_addr  = wr_addr;
          ram_wdata = wr_data;
        end
      end
      CLEAR: begin
        // pointer only moves on cycles where the write actually lands
        if (!active) begin
          ram_we    = 1'b1;
          ram_addr  = ptr;
          ram_wdata = col;
          ptr_nx    = ptr + ADDR_W'(1);
          if (ptr == LAST_TILE) state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (!rst_n) begin
      ram_we    = 1'b0;
      ram_wdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      col       <= '0;
      act_d1    <= 1'b0;
      pix_color <= '0;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      col       <= col_nx;
      act_d1    <= active;
      pix_color <= act_d1 ? ram_rdata : '0;
    end
  end

`ifdef TILE_FB_WR_ERR_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                        wr_err <= 1'b0;
    else if (state == IDLE && clr_start) wr_err <= 1'b0;
    else if (wr_hit && wr_oob)         wr_err <= 1'b1;
  end
`else
  // out-of-range writes are simply dropped
`endif

endmodule

// File: tb/tb_tile_fb_ctrl.sv
// Randomized bench for tile_fb_ctrl against a queue/array framebuffer model,
// with a behavioural tile RAM attached to the ram_* port.
module tb_tile_fb_ctrl;
  localparam int NT = 768;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] hc, vc;
  logic [7:0] pix_color;
  logic       wr_valid, wr_ready;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;
  logic       clr_start;
  logic [7:0] clr_color;
  logic       clr_busy, clr_done;
  logic [9:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_wdata, ram_rdata;
`ifdef TILE_FB_WR_ERR_EN
  logic       wr_err;
`endif

  tile_fb_ctrl dut (
    .clk(clk), .rst_n(rst_n), .hc(hc), .vc(vc), .pix_color(pix_color),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_start(clr_start), .clr_color(clr_color), .clr_busy(clr_busy), .clr_done(clr_done),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
`ifdef TILE_FB_WR_ERR_EN
    , .wr_err(wr_err)
`endif
  );

  always #5 clk = ~clk;

  // tile RAM, one-cycle read latency
  logic [7:0] mem [NT];
  always @(posedge clk) begin
    if (ram_we && ram_addr < 10'd768) mem[ram_addr] <= ram_wdata;
    ram_rdata <= (ram_addr < 10'd768) ? mem[ram_addr] : 8'h00;
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference model: expected framebuffer plus pending clear writes
  logic [7:0] fb [NT];
  bit         fb_ok [NT];
  int         clr_q[$];
  logic [7:0] m_col;
  bit         m_done, m_err;
  logic [7:0] p1, px;
  bit         p1_ok, px_ok;
  bit         e_act, e_we, e_rdy, e_busy, e_chk_addr;
  int         e_addr, e_tile;
  logic [7:0] e_data;

  task automatic model_comb();
    e_act  = (hc < 10'd640) && (vc < 10'd480);
    e_tile = (int'(vc) / 20) * 32 + int'(hc) / 20;
    e_busy = (clr_q.size() != 0) || m_done;
    e_rdy  = !e_act && !e_busy && !clr_start;
    e_we = 0; e_data = 8'h00; e_addr = 0;
    e_chk_addr = e_act || (!e_busy && !clr_start && !wr_valid);
    if (e_act) e_addr = e_tile;
    else if (clr_q.size() != 0) begin
      e_we = 1; e_addr = clr_q[0]; e_data = m_col; e_chk_addr = 1;
    end else if (e_rdy && wr_valid && wr_addr < 10'd768) begin
      e_we = 1; e_addr = int'(wr_addr); e_data = wr_data; e_chk_addr = 1;
    end
    if (!rst_n) begin e_we = 0; e_chk_addr = 0; end
  endtask

  task automatic model_seq();
    if (!rst_n) begin
      clr_q.delete(); m_done = 0; m_err = 0;
      p1 = 8'h00; p1_ok = 1; px = 8'h00; px_ok = 1;
      return;
    end
    px = p1; px_ok = p1_ok;
    if (e_act) begin p1 = fb[e_tile]; p1_ok = fb_ok[e_tile]; end
    else begin p1 = 8'h00; p1_ok = 1; end
    if (m_done) m_done = 0;
    else if (clr_q.size() != 0) begin
      if (!e_act) begin
        fb[clr_q[0]] = m_col; fb_ok[clr_q[0]] = 1;
        void'(clr_q.pop_front());
        if (clr_q.size() == 0) m_done = 1;
      end
    end else if (clr_start) begin
      for (int i = 0; i < NT; i++) clr_q.push_back(i);
      m_col = clr_color; m_err = 0;
    end else if (wr_valid && e_rdy) begin
      if (wr_addr < 10'd768) begin fb[wr_addr] = wr_data; fb_ok[wr_addr] = 1; end
      else m_err = 1;
    end
  endtask

  task automatic settle();
    #1;
    model_comb();
    chk("ram_we", 32'(ram_we), 32'(e_we));
    if (e_chk_addr) chk("ram_addr", 32'(ram_addr), e_addr);
    if (e_we) chk("ram_wdata", 32'(ram_wdata), 32'(e_data));
    chk("wr_ready", 32'(wr_ready), 32'(e_rdy));
    chk("clr_busy", 32'(clr_busy), 32'(e_busy));
    chk("clr_done", 32'(clr_done), 32'(m_done));
    if (px_ok) chk("pix_color", 32'(pix_color), 32'(px));
`ifdef TILE_FB_WR_ERR_EN
    chk("wr_err", 32'(wr_err), 32'(m_err));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_seq();
    @(negedge clk);
  endtask

  task automatic cyc();
    settle();
    tick();
  endtask

  task automatic act_px();
    hc = 10'($urandom_range(639, 0));
    vc = 10'($urandom_range(479, 0));
  endtask

  task automatic free_px();
    if ($urandom_range(1, 0) == 1) begin
      hc = 10'($urandom_range(799, 640)); vc = 10'($urandom_range(524, 0));
    end else begin
      hc = 10'($urandom_range(799, 0));   vc = 10'($urandom_range(524, 480));
    end
  endtask

  task automatic fb_cmp(input string tag);
    int bad = 0;
    for (int i = 0; i < NT; i++) if (fb_ok[i] && mem[i] !== fb[i]) bad++;
    chk(tag, bad, 0);
  endtask

  task automatic count_mem(input logic [7:0] v, output int n);
    n = 0;
    for (int i = 0; i < NT; i++) if (mem[i] === v) n++;
  endtask

  int  nwe, ndn, nact, seg, cnt;
  bit  act_seg, acc;

  initial begin
    px_ok = 0; p1_ok = 0;
    rst_n = 0; hc = 0; vc = 0; wr_valid = 0; wr_addr = 0; wr_data = 0;
    clr_start = 0; clr_color = 0;
    tick();
    repeat (2) begin
      settle();
      chk("rst_pix", 32'(pix_color), 0);
      chk("rst_we", 32'(ram_we), 0);
      chk("rst_busy", 32'(clr_busy), 0);
      chk("rst_done", 32'(clr_done), 0);
      chk("rst_ready", 32'(wr_ready), 0);
      tick();
    end
    rst_n = 1;

    // write then read back through scan-out
    hc = 650; vc = 0; wr_valid = 1; wr_addr = 5; wr_data = 8'hE0;
    settle();
    chk("wr_rdy", 32'(wr_ready), 1); chk("wr_we", 32'(ram_we), 1); chk("wr_addr", 32'(ram_addr), 5);
    tick(); wr_valid = 0;
    hc = 100; settle(); chk("scan_addr5", 32'(ram_addr), 5); tick();
    hc = 101; cyc();
    hc = 102; settle(); chk("pix_e0", 32'(pix_color), 32'h0E0); tick();

    // write stalled by active video
    hc = 300; vc = 200; wr_valid = 1; wr_addr = 40; wr_data = 8'h1C;
    settle();
    chk("stall_rdy", 32'(wr_ready), 0); chk("stall_we", 32'(ram_we), 0); chk("stall_addr", 32'(ram_addr), 335);
    tick();
    hc = 639; cyc();
    hc = 640; settle(); chk("unstall_we", 32'(ram_we), 1); chk("unstall_addr", 32'(ram_addr), 40);
    tick(); wr_valid = 0;

    // out-of-range write completes but is dropped
    hc = 700; vc = 10; wr_valid = 1; wr_addr = 800; wr_data = 8'h77;
    settle(); chk("oob_rdy", 32'(wr_ready), 1); chk("oob_we", 32'(ram_we), 0);
    tick(); wr_valid = 0;
    cyc();

    // full clear during vblank
    hc = 0; vc = 490; clr_start = 1; clr_color = 8'h03;
    cyc(); clr_start = 0;
    nwe = 0; ndn = 0;
    for (int i = 1; i < 1000; i++) begin
      hc = 10'(i % 800);
      settle();
      if (ram_we) nwe++;
      if (clr_done) ndn++;
      tick();
    end
    chk("clr_writes", nwe, 768);
    chk("clr_done_once", ndn, 1);
    count_mem(8'h03, cnt); chk("clr_all03", cnt, NT);
    repeat (60) begin act_px(); cyc(); end

    // random traffic
    seg = 0; act_seg = 0;
    for (int i = 0; i < 4000; i++) begin
      if (seg == 0) begin seg = $urandom_range(40, 1); act_seg = ($urandom_range(1, 0) == 1); end
      seg--;
      if (act_seg) act_px(); else free_px();
      if (!wr_valid && $urandom_range(2, 0) == 0) begin
        wr_valid = 1;
        wr_addr  = ($urandom_range(7, 0) == 0) ? 10'($urandom_range(1023, 768)) : 10'($urandom_range(767, 0));
        wr_data  = 8'($urandom);
      end
      clr_start = (i == 500) || ($urandom_range(999, 0) == 0);
      clr_color = 8'($urandom);
      settle(); acc = wr_valid && e_rdy; tick();
      if (acc) wr_valid = 0;
    end
    clr_start = 0;
    for (int i = 0; i < 3000 && (wr_valid || clr_q.size() != 0 || m_done); i++) begin
      free_px(); settle(); acc = wr_valid && e_rdy; tick();
      if (acc) wr_valid = 0;
    end
    chk("drain_idle", 32'(clr_busy), 0);
    fb_cmp("rand_fb");

    // clear paused by active video; second clr_start ignored
    hc = 640; vc = 479; clr_start = 1; clr_color = 8'h03;
    cyc(); clr_start = 0;
    nact = 0; ndn = 0;
    for (int f = 0; f < 6; f++) begin
      for (int h = 640; h < 800; h++) begin
        hc = 10'(h);
        if (f == 1 && h == 700) begin clr_start = 1; clr_color = 8'hFF; end
        settle();
        if (f == 1 && h == 640) chk("pause_ptr", 32'(ram_addr), 160);
        if (clr_done) ndn++;
        tick(); clr_start = 0;
      end
      vc = 10'(f);
      for (int h = 0; h < 60; h++) begin
        hc = 10'(h); settle();
        if (ram_we) nact++;
        if (clr_done) ndn++;
        tick();
      end
      vc = 479;
    end
    chk("pause_act_we", nact, 0);
    chk("pause_done_once", ndn, 1);
    count_mem(8'h03, cnt); chk("pause_all03", cnt, NT);

    // reset mid-clear aborts without clr_done
    hc = 700; vc = 490; clr_start = 1; clr_color = 8'h5A;
    cyc(); clr_start = 0;
    for (int i = 0; i < 100; i++) begin hc = 10'(640 + i % 160); cyc(); end
    rst_n = 0; cyc(); cyc(); rst_n = 1;
    ndn = 0;
    for (int i = 0; i < 900; i++) begin
      hc = 10'(640 + i % 160); settle();
      if (clr_done) ndn++;
      tick();
    end
    chk("abort_no_done", ndn, 0);
    count_mem(8'h5A, cnt); chk("abort_partial", cnt, 100);
    fb_cmp("final_fb");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
